// File: rtl/mem_rmw_ctrl.sv
// Load/store access controller: read-modify-write for sub-word stores, load extract/extend.
// Define LOAD_SIGN_EXT_EN to sign-extend lb/lh results (zero-extended otherwise).
module mem_rmw_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;
    localparam logic [2:0] OP_LB = 3'b011;
    localparam logic [2:0] OP_LW = 3'b100;
    localparam logic [2:0] OP_LH = 3'b101;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RSP
    } state_t;

    state_t        state;
    state_t        next;
    logic [2:0]    op_q;
    logic [31:0]   wd_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic          wait_done;
    logic          op_load;
    logic          req_ill;
    logic          unused_addr_lsb;

    // Register view and memory view are byte-reversed; the swap is its own inverse.
    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op,
                                             input logic [31:0] rd);
        logic [23:0] hi_b;
        logic [15:0] hi_h;
        logic [31:0] r;
`ifdef LOAD_SIGN_EXT_EN
        hi_b = {24{rd[31]}};
        hi_h = {16{rd[23]}};
`else
        hi_b = '0;
        hi_h = '0;
`endif
        r = swap(rd);
        if (op == OP_LB) begin
            r = {hi_b, rd[31:24]};
        end else if (op == OP_LH) begin
            r = {hi_h, rd[23:16], rd[31:24]};
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] op,
                                          input logic [31:0] wd,
                                          input logic [31:0] rd);
        logic [31:0] r;
        r = {wd[7:0], wd[15:8], rd[15:0]};
        if (op == OP_SB) begin
            r = {wd[7:0], rd[23:0]};
        end
        return r;
    endfunction

    assign unused_addr_lsb = ^req_addr[1:0];
    assign req_ill   = (req_op[2:1] == 2'b11);
    assign op_load   = (op_q == OP_LB) || (op_q == OP_LW) || (op_q == OP_LH);
    assign wait_done = (cnt == LAST);

    assign req_ready = (state == ST_IDLE);
    assign mem_rd    = (state == ST_RD);
    assign mem_wr    = (state == ST_WR);
    assign rsp_valid = (state == ST_RSP);
    assign rsp_err   = rsp_valid && err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    unique case (1'b1)
                        req_ill:           next = ST_RSP;
                        (req_op == OP_SW): next = ST_WR;
                        default:           next = ST_RD;
                    endcase
                end
            end
            ST_RD:   next = ST_WAIT;
            ST_WAIT: begin
                if (wait_done) begin
                    next = op_load ? ST_RSP : ST_WR;
                end
            end
            ST_WR:   next = ST_RSP;
            ST_RSP:  next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        wd_q     <= req_wdata;
                        err_q    <= req_ill;
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        cnt      <= '0;
                        if (req_op == OP_SW) begin
                            mem_wdata <= swap(req_wdata);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        cnt <= '0;
                        if (op_load) begin
                            rsp_rdata <= load_ext(op_q, mem_rdata);
                        end else begin
                            mem_wdata <= merge(op_q, wd_q, mem_rdata);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: directed cases plus random requests vs a byte-lane model.
module tb_mem_rmw_ctrl;

    localparam int LAT = 3;
    localparam int AW  = 32;

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;
    localparam logic [2:0] OP_LB = 3'b011;
    localparam logic [2:0] OP_LW = 3'b100;
    localparam logic [2:0] OP_LH = 3'b101;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'hDEADBEEF;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    mem_rmw_ctrl #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory model: read data is valid only around the sampling edge LAT cycles after mem_rd.
    logic [31:0] mem [16];
    int ncyc = 0;
    int rd_at = -100;
    bit inited = 1'b0;

    always @(negedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            inited = 1'b1;
        end
        ncyc = ncyc + 1;
        if (mem_rd) rd_at = ncyc;
        if (mem_wr) mem[mem_addr[5:2]] = mem_wdata;
        mem_rdata = (ncyc == rd_at + LAT) ? mem[mem_addr[5:2]] : 32'hDEADBEEF;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op,
                                             input logic [31:0] w);
        int n;
        logic [31:0] r;
        r = '0;
        n = (op == OP_LB) ? 1 : (op == OP_LH) ? 2 : 4;
        for (int i = 0; i < n; i++) r[8*i +: 8] = w[31-8*i -: 8];
`ifdef LOAD_SIGN_EXT_EN
        if (n < 4 && r[8*n-1]) begin
            for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] op,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
        int n;
        logic [31:0] r;
        r = old;
        n = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
        for (int i = 0; i < n; i++) r[31-8*i -: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of the first idle cycle after the response.
    task automatic run(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
        bit ld;
        bit rmw;
        bit ill;
        int rd_c;
        int wr_c;
        int rsp_c;
        logic [31:0] old;
        logic [31:0] aligned;
        ill = (op[2:1] == 2'b11);
        ld = (op == OP_LB) || (op == OP_LW) || (op == OP_LH);
        rmw = (op == OP_SB) || (op == OP_SH);
        rd_c = (ld || rmw) ? 1 : -1;
        wr_c = (op == OP_SW) ? 1 : rmw ? 2 + LAT : -1;
        rsp_c = ill ? 1 : (op == OP_SW) ? 2 : ld ? 2 + LAT : 3 + LAT;
        aligned = {addr[31:2], 2'b00};
        old = mem[addr[5:2]];
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_wdata = wd;
        chk("ready_pre", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_op = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        for (int c = 1; c <= rsp_c + 1; c++) begin
            @(negedge clk);
            if (c == rsp_c && ld) exp_rdata = ref_load(op, old);
            chk("mem_rd", 32'(mem_rd), 32'(c == rd_c));
            chk("mem_wr", 32'(mem_wr), 32'(c == wr_c));
            chk("rsp_valid", 32'(rsp_valid), 32'(c == rsp_c));
            chk("rsp_err", 32'(rsp_err), 32'(c == rsp_c && ill));
            chk("req_ready", 32'(req_ready), 32'(c == rsp_c + 1));
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            if (c == rd_c || c == wr_c) chk("mem_addr", mem_addr, aligned);
            if (c == wr_c) chk("mem_wdata", mem_wdata, ref_store(op, old, wd));
        end
        if (op == OP_SW || rmw) chk("mem_word", mem[addr[5:2]], ref_store(op, old, wd));
        else chk("mem_keep", mem[addr[5:2]], old);
    endtask

    initial begin
        logic [31:0] old;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        run(OP_SW, 32'h13, 32'h11223344);
        chk("sw_word", mem[4], 32'h44332211);
        run(OP_SW, 32'h10, 32'hDDCCBBAA);
        chk("sw_init", mem[4], 32'hAABBCCDD);
        run(OP_SB, 32'h10, 32'h000000EE);
        chk("sb_word", mem[4], 32'hEEBBCCDD);
        run(OP_SW, 32'h10, 32'hDDCCBBAA);
        run(OP_SH, 32'h12, 32'h00001234);
        chk("sh_word", mem[4], 32'h3412CCDD);
        run(OP_SW, 32'h10, 32'hDDCCBBAA);
        run(OP_LW, 32'h11, 32'h0);
        chk("lw_val", rsp_rdata, 32'hDDCCBBAA);
        run(OP_SW, 32'h10, 32'h5);
        run(OP_SW, 32'h10, 32'hDDCCBBAA);
        run(OP_LH, 32'h10, 32'h0);
`ifdef LOAD_SIGN_EXT_EN
        chk("lh_val", rsp_rdata, 32'hFFFFBBAA);
`else
        chk("lh_val", rsp_rdata, 32'h0000BBAA);
`endif
        run(OP_LB, 32'h10, 32'h0);
`ifdef LOAD_SIGN_EXT_EN
        chk("lb_val", rsp_rdata, 32'hFFFFFFAA);
`else
        chk("lb_val", rsp_rdata, 32'h000000AA);
`endif
        run(3'b111, 32'h10, 32'h12345678);
        run(3'b110, 32'h20, 32'h9ABCDEF0);
        chk("ill_hold", rsp_rdata, exp_rdata);

        for (int k = 0; k < 60; k++) begin
            run(3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        req_valid = 1'b0;

        old = mem[4];
        req_valid = 1'b1;
        req_op = OP_SB;
        req_addr = 32'h10;
        req_wdata = 32'h000000EE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        exp_rdata = '0;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_mem_rd", 32'(mem_rd), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_wr", 32'(mem_wr), 32'd0);
            chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("post_rst_word", mem[4], old);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
